palindrome_range_scanner: RTL

Sequential sweep controller that sits directly upstream of the combinational decimal palindrome checker. On a start request it drives every number in an inclusive range `[range_lo, range_hi]` onto the checker's `number` input, one value per clock. It samples the checker's `is_palindrome` result in the same cycle, counts the hits and records the most recent one. It reports completion with a one-cycle `done` pulse.

---
 rtl/palindrome_range_scanner.sv | 112 +++++++++++
 1 files changed

// File: rtl/palindrome_range_scanner.sv
// Sweeps number over [range_lo, range_hi] one value per clock, counting palindrome hits reported by
// the downstream combinational checker. Optional early termination via the SCAN_ABORT_EN macro.
module palindrome_range_scanner #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] range_lo,
    input  logic [WIDTH-1:0] range_hi,
    output logic [WIDTH-1:0] number,
    input  logic             is_palindrome,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hit_count,
    output logic [WIDTH-1:0] last_hit,
    output logic             hit_valid
`ifdef SCAN_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] number_q, number_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] hit_count_q, hit_count_d;
    logic [WIDTH-1:0] last_hit_q, last_hit_d;
    logic             hit_valid_q, hit_valid_d;
    logic             abort_req;

`ifdef SCAN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            number_q    <= '0;
            hi_q        <= '0;
            hit_count_q <= '0;
            last_hit_q  <= '0;
            hit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            number_q    <= number_d;
            hi_q        <= hi_d;
            hit_count_q <= hit_count_d;
            last_hit_q  <= last_hit_d;
            hit_valid_q <= hit_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        number_d    = number_q;
        hi_d        = hi_q;
        hit_count_d = hit_count_q;
        last_hit_d  = last_hit_q;
        hit_valid_d = hit_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hi_d        = range_hi;
                    number_d    = range_lo;
                    hit_count_d = '0;
                    last_hit_d  = '0;
                    hit_valid_d = 1'b0;
                    state_d     = (range_lo > range_hi) ? S_DONE : S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (is_palindrome) begin
                    if (hit_count_q != '1) begin
                        hit_count_d = hit_count_q + 1'b1;
                    end
                    last_hit_d  = number_q;
                    hit_valid_d = 1'b1;
                end
                // Compare before incrementing so a range ending at all-ones never wraps.
                if (number_q == hi_q || abort_req) begin
                    state_d = S_DONE;
                end else begin
                    number_d = number_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign number    = number_q;
    assign busy      = (state_q == S_SWEEP);
    assign done      = (state_q == S_DONE);
    assign hit_count = hit_count_q;
    assign last_hit  = last_hit_q;
    assign hit_valid = hit_valid_q;

endmodule
